// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: one unified single-port memory shared by instruction fetch (IF) and the
// MEM-stage load/store path (LS). One access is in flight at a time against a fixed-latency
// memory. LS wins contested grants, except that IF is forced through after STARVE_MAX
// consecutive contested LS wins. A fetch can be killed in flight by if_flush_i.
//
// Ports:
//   clk_i, rst_ni              clock (rising edge), asynchronous active-low reset
//   if_req_i/if_addr_i         fetch request (level) and address
//   if_flush_i                 kill the current/in-flight fetch (one-cycle pulse)
//   if_valid_o/if_rdata_o      fetch completion pulse and instruction
//   ls_req_i/ls_we_i           load/store request (level), 1 = store
//   ls_addr_i/ls_wdata_i       data address and store data
//   ls_valid_o/ls_rdata_o      load/store completion pulse and load data
//   stall_f_o/stall_m_o        combinational stalls for the hazard unit
//   mem_en_o/mem_we_o          one-cycle access strobe and write enable
//   mem_addr_o/mem_wdata_o     access address and write data (held after mem_en_o falls)
//   mem_rdata_i                read data, valid MEM_LAT cycles after the mem_en_o cycle
module mem_port_arbiter #(
  parameter int unsigned MEM_LAT    = 2,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        if_req_i,
  input  logic [31:0] if_addr_i,
  input  logic        if_flush_i,
  output logic        if_valid_o,
  output logic [31:0] if_rdata_o,
  input  logic        ls_req_i,
  input  logic        ls_we_i,
  input  logic [31:0] ls_addr_i,
  input  logic [31:0] ls_wdata_i,
  output logic        ls_valid_o,
  output logic [31:0] ls_rdata_o,
  output logic        stall_f_o,
  output logic        stall_m_o,
  output logic        mem_en_o,
  output logic        mem_we_o,
  output logic [31:0] mem_addr_o,
  output logic [31:0] mem_wdata_o,
  input  logic [31:0] mem_rdata_i
);

  localparam int unsigned CntW    = $clog2(MEM_LAT + 1);
  localparam int unsigned StarveW = (STARVE_MAX > 0) ? $clog2(STARVE_MAX + 1) : 1;

  typedef enum logic [0:0] {StIdle, StWait} state_e;
  typedef enum logic [0:0] {OwnIf, OwnLs} owner_e;

  state_e              state_q;
  owner_e              owner_q;
  logic [CntW-1:0]     cnt_q;
  logic [StarveW-1:0]  starve_q;
  logic                kill_q;
  logic                mem_en_q, mem_we_q;
  logic [31:0]         mem_addr_q, mem_wdata_q;
  logic                if_valid_q, ls_valid_q;
  logic [31:0]         if_rdata_q, ls_rdata_q;

  logic if_elig, ls_elig, starve_hit, grant_ls, grant_if;

  // A port whose valid is high this cycle still presents its old request, so it is skipped.
  always_comb begin
    if_elig    = if_req_i & ~if_flush_i & ~if_valid_q;
    ls_elig    = ls_req_i & ~ls_valid_q;
    starve_hit = (STARVE_MAX != 0) && (starve_q == StarveW'(STARVE_MAX));
    grant_ls   = ls_elig & ~(if_elig & starve_hit);
    grant_if   = if_elig & ~grant_ls;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q     <= StIdle;
      owner_q     <= OwnIf;
      cnt_q       <= '0;
      starve_q    <= '0;
      kill_q      <= 1'b0;
      mem_en_q    <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      if_valid_q  <= 1'b0;
      ls_valid_q  <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      mem_en_q   <= 1'b0;
      if_valid_q <= 1'b0;
      ls_valid_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (grant_ls) begin
            mem_en_q    <= 1'b1;
            mem_we_q    <= ls_we_i;
            mem_addr_q  <= ls_addr_i;
            mem_wdata_q <= ls_wdata_i;
            owner_q     <= OwnLs;
            cnt_q       <= CntW'(MEM_LAT);
            state_q     <= StWait;
            // Saturate so strict priority (STARVE_MAX = 0) cannot wrap the counter.
            if (if_elig && (starve_q != StarveW'(STARVE_MAX))) begin
              starve_q <= starve_q + 1'b1;
            end
          end else if (grant_if) begin
            mem_en_q   <= 1'b1;
            mem_we_q   <= 1'b0;
            mem_addr_q <= if_addr_i;
            owner_q    <= OwnIf;
            cnt_q      <= CntW'(MEM_LAT);
            state_q    <= StWait;
            starve_q   <= '0;
          end
        end
        StWait: begin
          if (cnt_q == '0) begin
            state_q <= StIdle;
            kill_q  <= 1'b0;
            if (owner_q == OwnLs) begin
              ls_valid_q <= 1'b1;
              if (!mem_we_q) ls_rdata_q <= mem_rdata_i;
            end else if (!kill_q && !if_flush_i) begin
              // A flush landing on the completion cycle also suppresses the fetch.
              if_valid_q <= 1'b1;
              if_rdata_q <= mem_rdata_i;
            end
          end else begin
            cnt_q <= cnt_q - 1'b1;
            if ((owner_q == OwnIf) && if_flush_i) kill_q <= 1'b1;
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign stall_f_o   = if_req_i & ~if_valid_q;
  assign stall_m_o   = ls_req_i & ~ls_valid_q;
  assign if_valid_o  = if_valid_q;
  assign if_rdata_o  = if_rdata_q;
  assign ls_valid_o  = ls_valid_q;
  assign ls_rdata_o  = ls_rdata_q;
  assign mem_en_o    = mem_en_q;
  assign mem_we_o    = mem_we_q;
  assign mem_addr_o  = mem_addr_q;
  assign mem_wdata_o = mem_wdata_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Testbench for mem_port_arbiter with MEM_LAT = 2 and STARVE_MAX = 2. A behavioural memory
// returns rd(addr) exactly MEM_LAT cycles after each mem_en cycle. Inputs are driven 1 ns
// after the rising edge and outputs are checked on the falling edge.
module tb_mem_port_arbiter;

  localparam int unsigned MemLat    = 2;
  localparam int unsigned StarveMax = 2;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        if_req, if_flush, if_valid;
  logic [31:0] if_addr, if_rdata;
  logic        ls_req, ls_we, ls_valid;
  logic [31:0] ls_addr, ls_wdata, ls_rdata;
  logic        stall_f, stall_m, mem_en, mem_we;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_port_arbiter #(
    .MEM_LAT   (MemLat),
    .STARVE_MAX(StarveMax)
  ) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .if_req_i   (if_req),
    .if_addr_i  (if_addr),
    .if_flush_i (if_flush),
    .if_valid_o (if_valid),
    .if_rdata_o (if_rdata),
    .ls_req_i   (ls_req),
    .ls_we_i    (ls_we),
    .ls_addr_i  (ls_addr),
    .ls_wdata_i (ls_wdata),
    .ls_valid_o (ls_valid),
    .ls_rdata_o (ls_rdata),
    .stall_f_o  (stall_f),
    .stall_m_o  (stall_m),
    .mem_en_o   (mem_en),
    .mem_we_o   (mem_we),
    .mem_addr_o (mem_addr),
    .mem_wdata_o(mem_wdata),
    .mem_rdata_i(mem_rdata)
  );

  function automatic logic [31:0] rd(input logic [31:0] a);
    return (a == 32'h10) ? 32'h0050_0093 : (a ^ 32'hC0DE_0000) + 32'd7;
  endfunction

  // Fixed-latency memory; garbage outside the valid slot exposes timing errors.
  logic [31:0] pipe [MemLat];
  always_ff @(posedge clk) begin
    pipe[0] <= mem_en ? rd(mem_addr) : 32'hBAD0_BAD0;
    for (int i = 1; i < MemLat; i++) pipe[i] <= pipe[i-1];
  end
  assign mem_rdata = pipe[MemLat-1];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        ls_req;
    logic        ls_we;
    logic [31:0] ls_addr;
    logic        e_en;
    logic        e_we;
    logic [31:0] e_addr;
    logic        e_ifv;
    logic [31:0] e_ifd;
    logic        e_lsv;
    logic [31:0] e_lsd;
    logic        e_sf;
    logic        e_sm;
  } vec_t;

  function automatic vec_t mkv(logic ir, logic [31:0] ia, logic lr, logic lw, logic [31:0] la,
                               logic en, logic we, logic [31:0] ad, logic iv, logic [31:0] id,
                               logic lv, logic [31:0] ld, logic sf, logic sm);
    vec_t v;
    v.if_req = ir; v.if_addr = ia; v.ls_req = lr; v.ls_we = lw; v.ls_addr = la;
    v.e_en = en; v.e_we = we; v.e_addr = ad; v.e_ifv = iv; v.e_ifd = id;
    v.e_lsv = lv; v.e_lsd = ld; v.e_sf = sf; v.e_sm = sm;
    return v;
  endfunction

  vec_t vecs [16];

  initial begin
    // Single fetch (rows 0-5), then IF/LS contention (rows 6-15).
    vecs[0]  = mkv(1, 32'h10, 0, 0, 0,       0, 0, 0,       0, 0,            0, 0,          1, 0);
    vecs[1]  = mkv(1, 32'h10, 0, 0, 0,       1, 0, 32'h10,  0, 0,            0, 0,          1, 0);
    vecs[2]  = mkv(1, 32'h10, 0, 0, 0,       0, 0, 0,       0, 0,            0, 0,          1, 0);
    vecs[3]  = mkv(1, 32'h10, 0, 0, 0,       0, 0, 0,       0, 0,            0, 0,          1, 0);
    vecs[4]  = mkv(1, 32'h10, 0, 0, 0,       0, 0, 0,       1, 32'h00500093, 0, 0,          0, 0);
    vecs[5]  = mkv(0, 0,      0, 0, 0,       0, 0, 0,       0, 0,            0, 0,          0, 0);
    vecs[6]  = mkv(1, 32'h14, 1, 0, 32'h2000, 0, 0, 0,      0, 0,            0, 0,          1, 1);
    vecs[7]  = mkv(1, 32'h14, 1, 0, 32'h2000, 1, 0, 32'h2000, 0, 0,          0, 0,          1, 1);
    vecs[8]  = mkv(1, 32'h14, 1, 0, 32'h2000, 0, 0, 0,      0, 0,            0, 0,          1, 1);
    vecs[9]  = mkv(1, 32'h14, 1, 0, 32'h2000, 0, 0, 0,      0, 0,            0, 0,          1, 1);
    vecs[10] = mkv(1, 32'h14, 1, 0, 32'h2000, 0, 0, 0,      0, 0,            1, rd(32'h2000), 1, 0);
    vecs[11] = mkv(1, 32'h14, 0, 0, 0,       1, 0, 32'h14,  0, 0,            0, 0,          1, 0);
    vecs[12] = mkv(1, 32'h14, 0, 0, 0,       0, 0, 0,       0, 0,            0, 0,          1, 0);
    vecs[13] = mkv(1, 32'h14, 0, 0, 0,       0, 0, 0,       0, 0,            0, 0,          1, 0);
    vecs[14] = mkv(1, 32'h14, 0, 0, 0,       0, 0, 0,       1, rd(32'h14),   0, 0,          0, 0);
    vecs[15] = mkv(0, 0,      0, 0, 0,       0, 0, 0,       0, 0,            0, 0,          0, 0);

    // Reset held with both requests pending.
    rst_n = 1'b0; if_flush = 0; ls_we = 0; ls_wdata = 0;
    if_req = 1; if_addr = 32'h200; ls_req = 1; ls_addr = 32'h2100;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst mem_en", mem_en, 0);       chk("rst mem_we", mem_we, 0);
    chk("rst mem_addr", mem_addr, 0);   chk("rst mem_wdata", mem_wdata, 0);
    chk("rst if_valid", if_valid, 0);   chk("rst ls_valid", ls_valid, 0);
    chk("rst if_rdata", if_rdata, 0);   chk("rst ls_rdata", ls_rdata, 0);
    chk("rst stall_f", stall_f, 1);     chk("rst stall_m", stall_m, 1);
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) rst_n = 1'b1;
      if (c == 5) ls_req = 0;
      if (c == 9) if_req = 0;
      @(negedge clk);
      if (c == 0) chk("rel no early mem_en", mem_en, 0);
      if (c == 1) begin chk("rel ls mem_en", mem_en, 1); chk("rel ls addr", mem_addr, 32'h2100); end
      if (c == 4) begin chk("rel ls_valid", ls_valid, 1); chk("rel ls_rdata", ls_rdata, rd(32'h2100)); end
      if (c == 5) begin chk("rel if mem_en", mem_en, 1); chk("rel if addr", mem_addr, 32'h200); end
      if (c == 8) begin chk("rel if_valid", if_valid, 1); chk("rel if_rdata", if_rdata, rd(32'h200)); end
    end

    // Table-driven vectors.
    for (int k = 0; k < 16; k++) begin
      step();
      if_req = vecs[k].if_req; if_addr = vecs[k].if_addr;
      ls_req = vecs[k].ls_req; ls_we = vecs[k].ls_we; ls_addr = vecs[k].ls_addr;
      @(negedge clk);
      chk($sformatf("vec%0d mem_en", k), mem_en, vecs[k].e_en);
      if (vecs[k].e_en) begin
        chk($sformatf("vec%0d mem_we", k), mem_we, vecs[k].e_we);
        chk($sformatf("vec%0d mem_addr", k), mem_addr, vecs[k].e_addr);
      end
      chk($sformatf("vec%0d if_valid", k), if_valid, vecs[k].e_ifv);
      if (vecs[k].e_ifv) chk($sformatf("vec%0d if_rdata", k), if_rdata, vecs[k].e_ifd);
      chk($sformatf("vec%0d ls_valid", k), ls_valid, vecs[k].e_lsv);
      if (vecs[k].e_lsv) chk($sformatf("vec%0d ls_rdata", k), ls_rdata, vecs[k].e_lsd);
      chk($sformatf("vec%0d stall_f", k), stall_f, vecs[k].e_sf);
      chk($sformatf("vec%0d stall_m", k), stall_m, vecs[k].e_sm);
    end

    // Flush mid-WAIT kills 0x20; 0x40 follows once the killed access drains.
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) begin if_req = 1; if_addr = 32'h20; end
      if (c == 2) if_flush = 1;
      if (c == 3) begin if_flush = 0; if_addr = 32'h40; end
      if (c == 9) if_req = 0;
      @(negedge clk);
      if (c == 1) begin chk("flA en", mem_en, 1); chk("flA addr", mem_addr, 32'h20); end
      if (c == 4) begin chk("flA killed valid", if_valid, 0); chk("flA no en", mem_en, 0); end
      if (c == 4) chk("flA stall_f", stall_f, 1);
      if (c == 5) begin chk("flA en2", mem_en, 1); chk("flA addr2", mem_addr, 32'h40); end
      if (c == 8) begin chk("flA valid", if_valid, 1); chk("flA rdata", if_rdata, rd(32'h40)); end
    end

    // Flush coinciding with completion suppresses that fetch's valid.
    for (int c = 0; c < 10; c++) begin
      step();
      if (c == 0) begin if_req = 1; if_addr = 32'h24; end
      if (c == 3) if_flush = 1;
      if (c == 4) begin if_flush = 0; if_addr = 32'h44; end
      if (c == 9) if_req = 0;
      @(negedge clk);
      if (c == 4) chk("flB killed valid", if_valid, 0);
      if (c == 5) begin chk("flB en", mem_en, 1); chk("flB addr", mem_addr, 32'h44); end
      if (c == 8) begin chk("flB valid", if_valid, 1); chk("flB rdata", if_rdata, rd(32'h44)); end
    end

    // Starvation: flush pulses hide IF on LS valid cycles so contested wins accumulate.
    for (int c = 0; c < 29; c++) begin
      step();
      if (c == 0) begin if_req = 1; if_addr = 32'h100; ls_req = 1; ls_we = 0; ls_addr = 32'h3000; end
      if (c == 4 || c == 9 || c == 18) if_flush = 1;
      if (c == 5) begin if_flush = 0; ls_addr = 32'h3004; end
      if (c == 10) begin if_flush = 0; ls_addr = 32'h3008; end
      if (c == 15) if_addr = 32'h104;
      if (c == 19) begin if_flush = 0; ls_addr = 32'h300C; end
      if (c == 24) ls_req = 0;
      if (c == 28) if_req = 0;
      @(negedge clk);
      if (c == 1) begin chk("stv en1", mem_en, 1); chk("stv addr1 ls", mem_addr, 32'h3000); end
      if (c == 4) chk("stv lsv1", ls_valid, 1);
      if (c == 6) begin chk("stv en2", mem_en, 1); chk("stv addr2 ls", mem_addr, 32'h3004); end
      if (c == 9) chk("stv lsv2", ls_valid, 1);
      if (c == 11) begin chk("stv en3", mem_en, 1); chk("stv addr3 if", mem_addr, 32'h100); end
      if (c == 11) chk("stv we3", mem_we, 0);
      if (c == 14) begin chk("stv ifv", if_valid, 1); chk("stv ifd", if_rdata, rd(32'h100)); end
      if (c == 15) begin chk("stv en4", mem_en, 1); chk("stv addr4 ls", mem_addr, 32'h3008); end
      if (c == 18) begin chk("stv lsv4", ls_valid, 1); chk("stv lsd4", ls_rdata, rd(32'h3008)); end
      if (c == 20) begin chk("stv en5", mem_en, 1); chk("stv addr5 ls", mem_addr, 32'h300C); end
      if (c == 23) begin chk("stv lsv5", ls_valid, 1); chk("stv lsd5", ls_rdata, rd(32'h300C)); end
      if (c == 24) begin chk("stv en6", mem_en, 1); chk("stv addr6 if", mem_addr, 32'h104); end
      if (c == 27) begin chk("stv ifv6", if_valid, 1); chk("stv ifd6", if_rdata, rd(32'h104)); end
    end

    // Store, then reset in the WAIT of the following load.
    for (int c = 0; c < 14; c++) begin
      step();
      if (c == 0) begin ls_req = 1; ls_we = 1; ls_addr = 32'h2004; ls_wdata = 32'hDEAD_BEEF; end
      if (c == 5) begin ls_we = 0; ls_addr = 32'h2008; ls_wdata = 0; end
      if (c == 7) rst_n = 1'b0;
      if (c == 8) rst_n = 1'b1;
      if (c == 13) ls_req = 0;
      @(negedge clk);
      if (c == 1) begin
        chk("st en", mem_en, 1);        chk("st we", mem_we, 1);
        chk("st addr", mem_addr, 32'h2004); chk("st wdata", mem_wdata, 32'hDEAD_BEEF);
      end
      if (c == 2) begin
        chk("st en low", mem_en, 0); chk("st we hold", mem_we, 1);
        chk("st wdata hold", mem_wdata, 32'hDEAD_BEEF);
      end
      if (c == 4) begin chk("st lsv", ls_valid, 1); chk("st rdata kept", ls_rdata, rd(32'h300C)); end
      if (c == 6) begin chk("ld en", mem_en, 1); chk("ld addr", mem_addr, 32'h2008); end
      if (c == 7) begin
        chk("mrst mem_we", mem_we, 0);      chk("mrst mem_addr", mem_addr, 0);
        chk("mrst mem_wdata", mem_wdata, 0); chk("mrst ls_rdata", ls_rdata, 0);
        chk("mrst if_rdata", if_rdata, 0);  chk("mrst ls_valid", ls_valid, 0);
        chk("mrst stall_m", stall_m, 1);
      end
      if (c == 8) chk("mrst no en", mem_en, 0);
      if (c == 9) begin chk("rs en", mem_en, 1); chk("rs addr", mem_addr, 32'h2008); end
      if (c == 11) chk("rs lsv early", ls_valid, 0);
      if (c == 12) begin chk("rs lsv", ls_valid, 1); chk("rs rdata", ls_rdata, rd(32'h2008)); end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  // Structural safety net: no back-to-back strobes.
  logic mem_en_prev = 1'b0;
  always @(negedge clk) begin
    if (mem_en && mem_en_prev) begin
      errors++;
      $display("FAIL mem_en back-to-back: got 1, expected 0");
    end
    mem_en_prev = mem_en;
  end

endmodule
